digdug_scan_timing: RTL and testbench
=====================================

// Module: digdug_scan_timing
// PURPOSE
//  Raster timing generator and pixel output stage wrapped around the DigDug core.
//  Derives the 6 MHz pixel enable from the 48 MHz master clock and generates PH/PV for the core.
//  Consumes the core's 8-bit POUT and emits blanked RGB 3:3:2 with HSYNC/VSYNC/DE.
//  Blank and sync are delayed to line up with the video pipeline latency.
// PARAMETERS
//  CLK_DIV   8    MCLK cycles per pixel; PCE period
//  H_TOTAL   384  pixels per line; PH counts 0..H_TOTAL-1
//  H_ACTIVE  288  visible pixels; PH < H_ACTIVE is active
//  HS_START  304  PH at which HSYNC asserts, before HOFS is applied
//  HS_WIDTH  32   HSYNC width in pixels
//  V_TOTAL   264  lines per frame; PV counts 0..V_TOTAL-1
//  V_ACTIVE  224  visible lines; PV < V_ACTIVE is active
//  VS_START  240  PV at which VSYNC asserts, before VOFS is applied
//  VS_WIDTH  3    VSYNC width in lines
//  PIPE      2    pixel periods from PH/PV to matching POUT; range 0..7
// PORTS
//  MCLK     in   1  master clock, 48 MHz
//  RESET_N  in   1  asynchronous active-low reset
//  HOFS     in   4  signed horizontal centring offset, -8..+7 pixels
//  VOFS     in   4  signed vertical centring offset, -8..+7 lines
//  POUT     in   8  pixel from core, {R[2:0],G[2:0],B[1:0]}
//  PCE      out  1  pixel clock enable; high for exactly 1 MCLK per pixel
//  PH       out  9  horizontal count to the core
//  PV       out  9  vertical count to the core
//  HBLK     out  1  horizontal blank, aligned with R/G/B
//  VBLK     out  1  vertical blank, aligned with R/G/B
//  HSYNC    out  1  active-high horizontal sync, aligned with R/G/B
//  VSYNC    out  1  active-high vertical sync, aligned with R/G/B
//  DE       out  1  ~HBLK & ~VBLK
//  R,G      out  3  red and green
//  B        out  2  blue
// BEHAVIOUR
//  Reset (RESET_N=0, async): divider, PH, PV and every output are 0, including PCE and DE.
//   Pipeline shift registers clear to 0. Release is synchronous to the next MCLK edge.
//  Divider: div counts 0..CLK_DIV-1 and wraps. PCE is registered and high while div==CLK_DIV-1.
//   First PCE comes CLK_DIV MCLKs after reset release.
//  Counters advance only on MCLK edges where PCE=1.
//   PH==H_TOTAL-1 -> PH=0 and PV increments; PV==V_TOTAL-1 at that point -> PV=0.
//   PH/PV change together on one edge; no intermediate value is ever visible.
//  Raw timing, combinational from the current PH/PV:
//   hb = PH>=H_ACTIVE; vb = PV>=V_ACTIVE
//   hs = (PH-hs0) mod H_TOTAL < HS_WIDTH, where hs0 = HS_START+sext(HOFS)
//   vs = (PV-vs0) mod V_TOTAL < VS_WIDTH, where vs0 = VS_START+sext(VOFS)
//   Use 10-bit arithmetic with modular wrap so sync windows may straddle count 0.
//  Alignment: on each PCE, {hb,vb,hs,vs} enter a PIPE-deep shift register.
//   PIPE=0 -> no register, raw values are used.
//   The PIPE-delayed tap plus one output register drives HBLK/VBLK/HSYNC/VSYNC.
//  Colour: on each PCE, R/G/B <= DE_next ? POUT fields : 0.
//   DE_next is the blank state loaded in the same edge. R/G/B are never non-zero while DE=0.
//  Offsets: HOFS/VOFS are sampled once per frame, on the PCE edge where PH and PV both wrap to 0.
//   A mid-frame change has no effect until the next frame.
//  All outputs hold between PCE edges; PH/PV are stable for CLK_DIV MCLKs.
//  Reset mid-line: everything returns to the reset state immediately.
//   The first post-reset frame starts at PH=PV=0.
// TESTING
//  T1 Release reset and count MCLKs.
//   -> first PCE at MCLK 8, then PCE every 8 MCLKs, each exactly 1 cycle wide.
//  T2 Run 2 frames.
//   -> PH wraps 383->0, PV wraps 263->0, frame = 384*264*8 = 811008 MCLKs.
//   -> PH/PV never exceed 383/263.
//  T3 HOFS=VOFS=0, PIPE=2.
//   -> HSYNC rises 3 PCEs after PH=304 (2 pipeline stages + 1 output register), lasts 32 PCEs.
//   -> VSYNC covers lines 240..242.
//   -> DE count per frame = 288*224 = 64512.
//  T4 POUT=8'hFF held constant.
//   -> R=7, G=7, B=3 exactly when DE=1; R=G=B=0 whenever DE=0.
//  T5 HOFS=4'h8 (-8), written mid-frame.
//   -> current frame unchanged.
//   -> next frame HSYNC starts at PH=296, same delay as T3.
//  T6 Pulse RESET_N low for 3 MCLKs at PH=150, PV=100.
//   -> all outputs 0 during reset; afterwards PH/PV restart from 0 and T1 timing holds.

Source files
------------

// File: rtl/digdug_scan_timing.sv
// Raster timing generator and pixel output stage for the DigDug core: derives the pixel
// enable, PH/PV counters, pipeline-aligned blank/sync and blanked RGB 3:3:2.
module digdug_scan_timing #(
   parameter int unsigned CLK_DIV  = 8,
   parameter int unsigned H_TOTAL  = 384,
   parameter int unsigned H_ACTIVE = 288,
   parameter int unsigned HS_START = 304,
   parameter int unsigned HS_WIDTH = 32,
   parameter int unsigned V_TOTAL  = 264,
   parameter int unsigned V_ACTIVE = 224,
   parameter int unsigned VS_START = 240,
   parameter int unsigned VS_WIDTH = 3,
   parameter int unsigned PIPE     = 2
) (
   input  logic       MCLK,
   input  logic       RESET_N,
   input  logic [3:0] HOFS,
   input  logic [3:0] VOFS,
   input  logic [7:0] POUT,
   output logic       PCE,
   output logic [8:0] PH,
   output logic [8:0] PV,
   output logic       HBLK,
   output logic       VBLK,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       DE,
   output logic [2:0] R,
   output logic [2:0] G,
   output logic [1:0] B
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] r_div;
   logic [DW-1:0] w_div_next;
   logic [3:0]    r_hofs;
   logic [3:0]    r_vofs;
   logic [9:0]    w_hs0, w_vs0, w_hd, w_vd, w_hmod, w_vmod;
   logic          w_hb, w_vb, w_hs, w_vs;
   logic [3:0]    w_raw;
   logic [3:0]    w_tap;
   logic          w_de_next;
   logic          w_frame_wrap;

   assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;

   assign w_hb = PH >= 9'(H_ACTIVE);
   assign w_vb = PV >= 9'(V_ACTIVE);

   // Sync distance is taken modulo the line/frame length so windows may straddle count 0.
   assign w_hs0  = 10'(HS_START) + {{6{r_hofs[3]}}, r_hofs};
   assign w_vs0  = 10'(VS_START) + {{6{r_vofs[3]}}, r_vofs};
   assign w_hd   = {1'b0, PH} - w_hs0;
   assign w_vd   = {1'b0, PV} - w_vs0;
   assign w_hmod = w_hd[9] ? w_hd + 10'(H_TOTAL)
                 : ((w_hd >= 10'(H_TOTAL)) ? w_hd - 10'(H_TOTAL) : w_hd);
   assign w_vmod = w_vd[9] ? w_vd + 10'(V_TOTAL)
                 : ((w_vd >= 10'(V_TOTAL)) ? w_vd - 10'(V_TOTAL) : w_vd);
   assign w_hs   = w_hmod < 10'(HS_WIDTH);
   assign w_vs   = w_vmod < 10'(VS_WIDTH);
   assign w_raw  = {w_hb, w_vb, w_hs, w_vs};

   assign w_frame_wrap = (PH == 9'(H_TOTAL - 1)) && (PV == 9'(V_TOTAL - 1));
   assign w_de_next    = ~w_tap[3] & ~w_tap[2];

   generate
      if (PIPE == 0) begin : g_nopipe
         assign w_tap = w_raw;
      end else begin : g_pipe
         logic [3:0] r_pipe [PIPE];
         always_ff @(posedge MCLK or negedge RESET_N) begin
            if (!RESET_N) begin
               for (int unsigned i = 0; i < PIPE; i++) r_pipe[i] <= '0;
            end else if (PCE) begin
               r_pipe[0] <= w_raw;
               for (int unsigned i = 1; i < PIPE; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign w_tap = r_pipe[PIPE-1];
      end
   endgenerate

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_div  <= '0;
         r_hofs <= '0;
         r_vofs <= '0;
         PCE    <= 1'b0;
         PH     <= '0;
         PV     <= '0;
         HBLK   <= 1'b0;
         VBLK   <= 1'b0;
         HSYNC  <= 1'b0;
         VSYNC  <= 1'b0;
         DE     <= 1'b0;
         R      <= '0;
         G      <= '0;
         B      <= '0;
      end else begin
         r_div <= w_div_next;
         PCE   <= (w_div_next == DIV_LAST);
         if (PCE) begin
            if (PH == 9'(H_TOTAL - 1)) begin
               PH <= '0;
               PV <= (PV == 9'(V_TOTAL - 1)) ? '0 : PV + 9'd1;
            end else begin
               PH <= PH + 9'd1;
            end
            if (w_frame_wrap) begin
               r_hofs <= HOFS;
               r_vofs <= VOFS;
            end
            HBLK  <= w_tap[3];
            VBLK  <= w_tap[2];
            HSYNC <= w_tap[1];
            VSYNC <= w_tap[0];
            DE    <= w_de_next;
            R     <= w_de_next ? POUT[7:5] : '0;
            G     <= w_de_next ? POUT[4:2] : '0;
            B     <= w_de_next ? POUT[1:0] : '0;
         end
      end
   end

endmodule

// File: tb/tb_digdug_scan_timing.sv
// Bench for digdug_scan_timing: raster-position reference model with a delay queue,
// plus literal checks on PCE timing, frame length, DE count and sync placement.
module tb_digdug_scan_timing;

   localparam int CD  = 4;
   localparam int HT  = 48;
   localparam int HA  = 36;
   localparam int HSS = 38;
   localparam int HSW = 4;
   localparam int VT  = 20;
   localparam int VA  = 14;
   localparam int VSS = 15;
   localparam int VSW = 3;
   localparam int PP  = 2;
   localparam int FRAME = HT * VT * CD;

   logic       MCLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic [3:0] HOFS = 4'h0;
   logic [3:0] VOFS = 4'h0;
   logic [7:0] POUT = 8'h00;
   logic       PCE, HBLK, VBLK, HSYNC, VSYNC, DE;
   logic [8:0] PH, PV;
   logic [2:0] R, G;
   logic [1:0] B;

   digdug_scan_timing #(
      .CLK_DIV(CD), .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_WIDTH(HSW),
      .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_WIDTH(VSW), .PIPE(PP)
   ) dut (
      .MCLK(MCLK), .RESET_N(RESET_N), .HOFS(HOFS), .VOFS(VOFS), .POUT(POUT),
      .PCE(PCE), .PH(PH), .PV(PV), .HBLK(HBLK), .VBLK(VBLK), .HSYNC(HSYNC),
      .VSYNC(VSYNC), .DE(DE), .R(R), .G(G), .B(B)
   );

   always #5 MCLK = ~MCLK;

   int tests = 0;
   int fails = 0;

   // reference model state
   int         e;
   int         mph, mpv, mho, mvo;
   logic [3:0] q[$];
   logic       eP, eHB, eVB, eHS, eVS, eDE;
   logic [7:0] eRGB;

   // literal monitor state
   int   first_pce_e, last_pce_e, last_frame_e, de_cnt, rise_e, vrise_e;
   int   exp_rise_ph;
   bit   lit_on, pending;
   logic [8:0] pPH, pPV;
   logic pHS, pVS;
   int   rand_mode;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: actual=%0d expected=%0d (edge %0d)", name, act, exp, e);
      end
   endtask

   function automatic logic [31:0] dut_vec();
      return {PCE, PH, PV, HBLK, VBLK, HSYNC, VSYNC, DE, R, G, B};
   endfunction

   function automatic logic [3:0] raw_now();
      int hd, vd;
      hd = ((mph - (HSS + mho)) % HT + HT) % HT;
      vd = ((mpv - (VSS + mvo)) % VT + VT) % VT;
      return {mph >= HA, mpv >= VA, hd < HSW, vd < VSW};
   endfunction

   task automatic model_reset();
      e = 0; mph = 0; mpv = 0; mho = 0; mvo = 0;
      q.delete();
      for (int i = 0; i < PP; i++) q.push_back(4'h0);
      eP = 0; eHB = 0; eVB = 0; eHS = 0; eVS = 0; eDE = 0; eRGB = 8'h00;
      first_pce_e = -1; last_pce_e = -1; last_frame_e = 0; de_cnt = 0;
      rise_e = -1; vrise_e = -1;
      pPH = '0; pPV = '0; pHS = 0; pVS = 0;
   endtask

   // Inputs seen here are the values present at the edge just taken.
   task automatic model_step();
      logic [3:0] t;
      e++;
      if (e % CD == 0) begin
         q.push_back(raw_now());
         t = q.pop_front();
         {eHB, eVB, eHS, eVS} = t;
         eDE  = !eHB && !eVB;
         eRGB = eDE ? POUT : 8'h00;
         if (mph == HT - 1) begin
            mph = 0;
            if (mpv == VT - 1) begin
               mpv = 0;
               mho = int'($signed(HOFS));
               mvo = int'($signed(VOFS));
            end else mpv++;
         end else mph++;
      end
      eP = ((e + 1) % CD == 0);
   endtask

   task automatic cycle();
      logic [31:0] expv, actv;
      @(posedge MCLK);
      #1;
      model_step();
      expv = {eP, 9'(mph), 9'(mpv), eHB, eVB, eHS, eVS, eDE, eRGB};
      actv = dut_vec();
      tests++;
      if (actv !== expv) begin
         fails++;
         $display("FAIL outputs @edge %0d: actual {PCE,PH,PV,HB,VB,HS,VS,DE,RGB}=%h expected %h", e, actv, expv);
      end
      if (PCE) begin
         de_cnt += int'(DE);
         if (first_pce_e < 0) begin
            first_pce_e = e;
            check("first_pce_mclk", e + 1, CD);
         end else check("pce_spacing", e - last_pce_e, CD);
         last_pce_e = e;
      end
      if (PH == 0 && PV == 0 && !(pPH == 0 && pPV == 0)) begin
         if (last_frame_e > 0) begin
            check("frame_len", e - last_frame_e, FRAME);
            check("de_per_frame", de_cnt, HA * VA);
         end
         last_frame_e = e;
         de_cnt = 0;
         if (pending) begin exp_rise_ph = HSS - 8 + PP + 1; pending = 0; end
      end
      if (HSYNC && !pHS) begin
         if (exp_rise_ph >= 0) check("hsync_rise_ph", int'(PH), exp_rise_ph);
         rise_e = e;
      end
      if (!HSYNC && pHS && rise_e >= 0) check("hsync_width", e - rise_e, HSW * CD);
      if (VSYNC && !pVS) begin
         if (lit_on) begin
            check("vsync_rise_pv", int'(PV), VSS);
            check("vsync_rise_ph", int'(PH), PP + 1);
         end
         vrise_e = e;
      end
      if (!VSYNC && pVS && lit_on && vrise_e >= 0) check("vsync_width", e - vrise_e, VSW * HT * CD);
      pPH = PH; pPV = PV; pHS = HSYNC; pVS = VSYNC;
      if (rand_mode == 0) POUT = 8'hFF;
      else POUT = 8'($urandom);
      if (rand_mode == 2 && $urandom_range(0, 400) == 0) begin
         HOFS = 4'($urandom);
         VOFS = 4'($urandom);
      end
   endtask

   task automatic run_until(input int ph, input int pv);
      int n = 0;
      while (!(PH == 9'(ph) && PV == 9'(pv)) && n < 2 * FRAME) begin
         cycle();
         n++;
      end
      check("reach_position", (PH == 9'(ph) && PV == 9'(pv)) ? 1 : 0, 1);
   endtask

   // Reset asserted between edges, held across 3 MCLK edges, released between edges.
   task automatic pulse_reset();
      #3 RESET_N = 1'b0;
      #1 check("reset_async_zero", int'(dut_vec()), 0);
      repeat (3) @(posedge MCLK);
      #1 check("reset_hold_zero", int'(dut_vec()), 0);
      model_reset();
      RESET_N = 1'b1;
   endtask

   initial begin
      rand_mode = 0; lit_on = 1; pending = 0; exp_rise_ph = HSS + PP + 1;
      model_reset();
      repeat (3) @(posedge MCLK);
      #1 check("reset_initial_zero", int'(dut_vec()), 0);
      RESET_N = 1'b1;

      // constant white pixel, then random pixels, zero offsets
      repeat (FRAME) cycle();
      rand_mode = 1;
      repeat (FRAME + FRAME / 2) cycle();

      // horizontal offset -8 written mid-frame
      run_until(10, 5);
      HOFS = 4'h8;
      pending = 1;
      repeat (2 * FRAME) cycle();

      // random offsets changing at arbitrary times
      lit_on = 0; exp_rise_ph = -1; rand_mode = 2;
      repeat (3 * FRAME) cycle();

      // reset mid-line
      rand_mode = 1; HOFS = 4'h0; VOFS = 4'h0;
      run_until(15, 10);
      pulse_reset();
      lit_on = 1; exp_rise_ph = HSS + PP + 1;
      repeat (FRAME + FRAME / 2) cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
      $fatal(1);
   end

endmodule
